// File: rtl/swc_multiport_page_allocator.sv
// swc_multiport_page_allocator
// Shared page allocator for the switch packet buffer. A round-robin arbiter
// picks one client port at a time to allocate a page (with an initial use
// count) or to free (decrement) a page. Never-used pages come from a fresh
// counter; returned pages are recycled through a FIFO in return order.
//
// Ports:
//   clk_i, rst_i    clock (rising edge), asynchronous active-high reset
//   alloc_i         per-port allocation request, held until alloc_done_o
//   free_i          per-port free request, held until free_done_o
//   alloc_done_o    one-cycle per-port strobe, allocation completed
//   free_done_o     one-cycle per-port strobe, free completed
//   pgaddr_free_i   per-port page to free (g_page_addr_bits per port)
//   usecnt_i        per-port initial use count (g_use_count_bits per port)
//   pgaddr_alloc_o  allocated page, valid with alloc_done_o, held afterwards
//
// Optional build macro SWC_PAGE_ALLOC_FREE_COUNT_EN adds:
//   free_count_o    registered number of free pages
//   nomem_o         high when no page is free
module swc_multiport_page_allocator #(
  parameter int g_num_ports      = 11,
  parameter int g_num_pages      = 1024,
  parameter int g_page_addr_bits = 10,
  parameter int g_use_count_bits = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [g_num_ports-1:0]                  alloc_i,
  input  logic [g_num_ports-1:0]                  free_i,
  output logic [g_num_ports-1:0]                  alloc_done_o,
  output logic [g_num_ports-1:0]                  free_done_o,
  input  logic [g_num_ports*g_page_addr_bits-1:0] pgaddr_free_i,
  input  logic [g_num_ports*g_use_count_bits-1:0] usecnt_i,
  output logic [g_page_addr_bits-1:0]             pgaddr_alloc_o
`ifdef SWC_PAGE_ALLOC_FREE_COUNT_EN
  ,
  output logic [g_page_addr_bits:0]               free_count_o,
  output logic                                    nomem_o
`endif
);

  localparam int c_port_bits = (g_num_ports > 1) ? $clog2(g_num_ports) : 1;
  localparam logic [g_page_addr_bits:0]   c_num_pages = (g_page_addr_bits+1)'(g_num_pages);
  localparam logic [g_page_addr_bits-1:0] c_last_page = g_page_addr_bits'(g_num_pages - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALLOC_RD,
    S_ALLOC_WR,
    S_FREE_RD,
    S_FREE_WR
  } state_t;

  state_t state, state_next;

  logic [g_use_count_bits-1:0] usecnt_ram [g_num_pages];
  logic [g_page_addr_bits-1:0] fifo_ram   [g_num_pages];

  logic [g_page_addr_bits:0]   fresh;
  logic [g_page_addr_bits-1:0] head, tail;
  logic [g_page_addr_bits:0]   free_count;
  logic [c_port_bits-1:0]      last_port, cur_port;
  logic [g_page_addr_bits-1:0] cur_page;
  logic [g_use_count_bits-1:0] cur_usecnt;
  logic                        use_fresh;
  logic [g_page_addr_bits-1:0] fifo_rd;
  logic [g_use_count_bits-1:0] usecnt_rd;

  logic [g_num_ports-1:0]      alloc_cand, free_cand;
  logic                        grant_valid, grant_alloc;
  logic [c_port_bits-1:0]      grant_port;
  logic [g_page_addr_bits-1:0] alloc_page;
  logic                        ram_we, push;
  logic [g_page_addr_bits-1:0] ram_waddr;
  logic [g_use_count_bits-1:0] ram_wdata;

  // Round-robin arbiter. A done bit asserted this cycle masks the same
  // request type of that port, because the requester drops its level one
  // cycle after seeing done. Allocs wait while no page is free.
  always_comb begin
    int idx;
    logic [c_port_bits-1:0] idx_p;
    idx         = 0;
    idx_p       = '0;
    alloc_cand  = alloc_i & ~alloc_done_o & {g_num_ports{free_count != '0}};
    free_cand   = free_i & ~free_done_o;
    grant_valid = 1'b0;
    grant_alloc = 1'b0;
    grant_port  = '0;
    for (int k = 1; k <= g_num_ports; k++) begin
      idx = int'(last_port) + k;
      if (idx >= g_num_ports) idx = idx - g_num_ports;
      idx_p = c_port_bits'(idx);
      if (!grant_valid && (alloc_cand[idx_p] || free_cand[idx_p])) begin
        grant_valid = 1'b1;
        grant_alloc = alloc_cand[idx_p];
        grant_port  = idx_p;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (grant_valid) state_next = grant_alloc ? S_ALLOC_RD : S_FREE_RD;
      S_ALLOC_RD: state_next = S_ALLOC_WR;
      S_ALLOC_WR: state_next = S_IDLE;
      S_FREE_RD:  state_next = S_FREE_WR;
      S_FREE_WR:  state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Fresh pages are handed out first; the FIFO head is only consumed once
  // the fresh counter has run past the last page.
  assign alloc_page = use_fresh ? fresh[g_page_addr_bits-1:0] : fifo_rd;

  // Single write port of the use-count RAM, plus the FIFO push decision
  // when a page's count drops from 1 to 0.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = alloc_page;
    ram_wdata = '0;
    push      = 1'b0;
    case (state)
      S_ALLOC_WR: begin
        ram_we    = 1'b1;
        ram_wdata = (cur_usecnt == '0) ? g_use_count_bits'(1) : cur_usecnt;
      end
      S_FREE_WR: begin
        ram_waddr = cur_page;
        if (usecnt_rd > g_use_count_bits'(1)) begin
          ram_we    = 1'b1;
          ram_wdata = usecnt_rd - g_use_count_bits'(1);
        end else if (usecnt_rd == g_use_count_bits'(1)) begin
          ram_we = 1'b1;
          push   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // RAMs carry no reset; their contents are only meaningful for pages the
  // allocator has handed out since the last reset.
  always_ff @(posedge clk_i) begin
    if (state == S_ALLOC_RD) fifo_rd <= fifo_ram[head];
    if (state == S_FREE_RD)  usecnt_rd <= usecnt_ram[cur_page];
    if (ram_we)              usecnt_ram[ram_waddr] <= ram_wdata;
    if (push)                fifo_ram[tail] <= cur_page;
  end

  // Control state, pointers, counters and the registered done strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      fresh          <= '0;
      head           <= '0;
      tail           <= '0;
      free_count     <= c_num_pages;
      last_port      <= '0;
      cur_port       <= '0;
      cur_page       <= '0;
      cur_usecnt     <= '0;
      use_fresh      <= 1'b0;
      alloc_done_o   <= '0;
      free_done_o    <= '0;
      pgaddr_alloc_o <= '0;
    end else begin
      state        <= state_next;
      alloc_done_o <= '0;
      free_done_o  <= '0;
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            cur_port   <= grant_port;
            last_port  <= grant_port;
            cur_page   <= pgaddr_free_i[int'(grant_port)*g_page_addr_bits +: g_page_addr_bits];
            cur_usecnt <= usecnt_i[int'(grant_port)*g_use_count_bits +: g_use_count_bits];
          end
        end
        S_ALLOC_RD: use_fresh <= (fresh < c_num_pages);
        S_ALLOC_WR: begin
          pgaddr_alloc_o         <= alloc_page;
          alloc_done_o[cur_port] <= 1'b1;
          free_count             <= free_count - (g_page_addr_bits+1)'(1);
          if (use_fresh)
            fresh <= fresh + (g_page_addr_bits+1)'(1);
          else
            head <= (head == c_last_page) ? '0 : head + g_page_addr_bits'(1);
        end
        S_FREE_WR: begin
          free_done_o[cur_port] <= 1'b1;
          if (push) begin
            tail       <= (tail == c_last_page) ? '0 : tail + g_page_addr_bits'(1);
            free_count <= free_count + (g_page_addr_bits+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SWC_PAGE_ALLOC_FREE_COUNT_EN
  assign free_count_o = free_count;
  assign nomem_o      = (free_count == '0);
`endif

endmodule

// File: tb/tb_swc_multiport_page_allocator.sv
// Testbench for swc_multiport_page_allocator. A behavioural model (fresh
// counter, queue of returned pages, per-page use counts) predicts every
// returned page and done strobe.
module tb_swc_multiport_page_allocator;

  localparam int NP  = 11;
  localparam int NPG = 1024;
  localparam int AW  = 10;
  localparam int UW  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     allocReq, freeReq, allocDone, freeDone;
  logic [NP*AW-1:0]  pgaddrFree;
  logic [NP*UW-1:0]  usecnt;
  logic [AW-1:0]     pgaddrAlloc;
`ifdef SWC_PAGE_ALLOC_FREE_COUNT_EN
  logic [AW:0]       freeCount;
  logic              nomem;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  int mFresh, mFreeCnt, mLast;
  int mQ[$];
  int mUse[NPG];
  int touched[$];
  bit isTouched[NPG];

  swc_multiport_page_allocator dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .alloc_i        (allocReq),
    .free_i         (freeReq),
    .alloc_done_o   (allocDone),
    .free_done_o    (freeDone),
    .pgaddr_free_i  (pgaddrFree),
    .usecnt_i       (usecnt),
    .pgaddr_alloc_o (pgaddrAlloc)
`ifdef SWC_PAGE_ALLOC_FREE_COUNT_EN
    ,
    .free_count_o   (freeCount),
    .nomem_o        (nomem)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    mFresh = 0; mFreeCnt = NPG; mLast = 0;
    mQ.delete(); touched.delete();
    for (int i = 0; i < NPG; i++) begin mUse[i] = 0; isTouched[i] = 1'b0; end
  endfunction

  function automatic int modelAlloc(input int port, input int cnt);
    int page;
    if (mFresh < NPG) begin page = mFresh; mFresh++; end
    else page = mQ.pop_front();
    mUse[page] = (cnt == 0) ? 1 : cnt;
    mFreeCnt--;
    mLast = port;
    if (!isTouched[page]) begin isTouched[page] = 1'b1; touched.push_back(page); end
    return page;
  endfunction

  function automatic void modelFree(input int port, input int page);
    if (mUse[page] > 1) mUse[page]--;
    else if (mUse[page] == 1) begin mUse[page] = 0; mQ.push_back(page); mFreeCnt++; end
    mLast = port;
  endfunction

  task automatic checkCount(input string tag);
`ifdef SWC_PAGE_ALLOC_FREE_COUNT_EN
    checkOutput({tag, " free_count"}, int'(freeCount), mFreeCnt);
    checkOutput({tag, " nomem"}, int'(nomem), (mFreeCnt == 0) ? 1 : 0);
`endif
  endtask

  task automatic applyAlloc(input int port, input int cnt, input string tag);
    int expPage, lat;
    bit seen;
    expPage = modelAlloc(port, cnt);
    usecnt[port*UW +: UW] = cnt[UW-1:0];
    allocReq[port] = 1'b1;
    seen = 1'b0; lat = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk); lat++;
      if (allocDone[port]) seen = 1'b1;
    end
    if (!seen) checkOutput({tag, " timeout"}, 0, 1);
    else begin
      checkOutput({tag, " alloc_vec"}, int'(allocDone), 1 << port);
      checkOutput({tag, " free_vec"}, int'(freeDone), 0);
      checkOutput({tag, " page"}, int'(pgaddrAlloc), expPage);
      checkOutput({tag, " latency"}, lat, 3);
    end
    allocReq[port] = 1'b0;
    @(negedge clk);
    checkOutput({tag, " strobe_len"}, int'(allocDone), 0);
    checkCount(tag);
  endtask

  task automatic applyFree(input int port, input int page, input string tag);
    int lat;
    bit seen;
    modelFree(port, page);
    pgaddrFree[port*AW +: AW] = page[AW-1:0];
    freeReq[port] = 1'b1;
    seen = 1'b0; lat = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk); lat++;
      if (freeDone[port]) seen = 1'b1;
    end
    if (!seen) checkOutput({tag, " timeout"}, 0, 1);
    else begin
      checkOutput({tag, " free_vec"}, int'(freeDone), 1 << port);
      checkOutput({tag, " alloc_vec"}, int'(allocDone), 0);
      checkOutput({tag, " latency"}, lat, 3);
    end
    freeReq[port] = 1'b0;
    @(negedge clk);
    checkOutput({tag, " strobe_len"}, int'(freeDone), 0);
    checkCount(tag);
  endtask

  // Several requests raised together; the expected completion order is the
  // round-robin rule applied to the pending set, alloc ahead of free.
  task automatic applyStimulus();
    bit pendA[NP], pendF[NP], relA[NP], relF[NP];
    int eP[$], eA[$], ePg[$];
    int extra, p, a, pg, idx;
    bit found, any;
    for (int i = 0; i < NP; i++) begin pendA[i] = 0; pendF[i] = 0; relA[i] = 0; relF[i] = 0; end
    pendA[2] = 1; pendA[4] = 1; pendF[2] = 1;
    any = 1'b1;
    while (any) begin
      found = 1'b0;
      for (int k = 1; k <= NP && !found; k++) begin
        idx = (mLast + k) % NP;
        if (pendA[idx] && mFreeCnt > 0) begin
          eP.push_back(idx); eA.push_back(1); ePg.push_back(modelAlloc(idx, 1));
          pendA[idx] = 0; found = 1'b1;
        end else if (pendF[idx]) begin
          eP.push_back(idx); eA.push_back(0); ePg.push_back(200);
          modelFree(idx, 200);
          pendF[idx] = 0; found = 1'b1;
        end
      end
      any = found;
    end
    usecnt[2*UW +: UW] = 4'd1;
    usecnt[4*UW +: UW] = 4'd1;
    pgaddrFree[2*AW +: AW] = 10'd200;
    allocReq[2] = 1'b1; allocReq[4] = 1'b1; freeReq[2] = 1'b1;
    extra = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      for (int q = 0; q < NP; q++) begin
        if (relA[q]) begin allocReq[q] = 1'b0; relA[q] = 0; end
        if (relF[q]) begin freeReq[q] = 1'b0; relF[q] = 0; end
      end
      if (allocDone != '0 || freeDone != '0) begin
        if (eP.size() == 0) extra++;
        else begin
          p = eP.pop_front(); a = eA.pop_front(); pg = ePg.pop_front();
          checkOutput("rr alloc_vec", int'(allocDone), (a != 0) ? (1 << p) : 0);
          checkOutput("rr free_vec", int'(freeDone), (a != 0) ? 0 : (1 << p));
          if (a != 0) checkOutput("rr page", int'(pgaddrAlloc), pg);
        end
        for (int q = 0; q < NP; q++) begin
          if (allocDone[q]) relA[q] = 1;
          if (freeDone[q]) relF[q] = 1;
        end
      end
    end
    allocReq = '0; freeReq = '0;
    checkOutput("rr remaining", eP.size(), 0);
    checkOutput("rr extra_done", extra, 0);
    @(negedge clk);
  endtask

  initial begin
    int expPage, seen, port, pg, lat;
    rst = 1'b1; allocReq = '0; freeReq = '0; pgaddrFree = '0; usecnt = '0;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset alloc_done", int'(allocDone), 0);
    checkOutput("reset free_done", int'(freeDone), 0);
    checkOutput("reset pgaddr", int'(pgaddrAlloc), 0);
    checkCount("reset");

    // First allocations, then pages up to 511 on scattered ports
    applyAlloc(5, 2, "first alloc");
    applyAlloc(0, 2, "second alloc");
    for (int i = 2; i < 512; i++) applyAlloc((i * 7123) % NP, 2, "bulk alloc");

    // Two rounds of frees: first only decrements, second returns pages
    for (int i = 0; i < 512; i++) applyFree((i * 23) % NP, i, "free round1");
    for (int i = 0; i < 512; i++) applyFree((i * 23) % NP, i, "free round2");

    // Drain every page: fresh 512..1023, then FIFO 0..511
    while (mFreeCnt > 0) applyAlloc($urandom_range(0, NP - 1), 1, "drain alloc");

    // Out of pages: port 3 waits until port 7 returns page 9
    usecnt[3*UW +: UW] = 4'd1;
    allocReq[3] = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (allocDone != '0) seen++;
    end
    checkOutput("nomem hold", seen, 0);
    applyFree(7, 9, "nomem free");
    expPage = modelAlloc(3, 1);
    seen = 0;
    for (int c = 0; c < 30 && seen == 0; c++) begin
      @(negedge clk);
      if (allocDone[3]) seen = 1;
    end
    checkOutput("nomem wakeup", seen, 1);
    if (seen != 0) checkOutput("nomem page", int'(pgaddrAlloc), expPage);
    allocReq[3] = 1'b0;
    @(negedge clk);

    // Concurrent requests in round-robin order
    applyFree(0, 100, "pre rr free");
    applyFree(0, 101, "pre rr free");
    applyStimulus();

    // Reset in the middle of an allocation
    usecnt[1*UW +: UW] = 4'd3;
    allocReq[1] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    allocReq = '0;
    @(negedge clk);
    checkOutput("midreset pgaddr", int'(pgaddrAlloc), 0);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (allocDone != '0 || freeDone != '0) seen++;
    end
    checkOutput("midreset no_done", seen, 0);
    modelReset();
    applyAlloc(6, 2, "post reset alloc");

    // Random mix of allocations and frees on random ports
    for (int i = 0; i < 300; i++) begin
      port = $urandom_range(0, NP - 1);
      if (touched.size() > 0 && ($urandom_range(0, 2) == 0 || mFreeCnt == 0)) begin
        pg = touched[$urandom_range(0, touched.size() - 1)];
        applyFree(port, pg, "rand free");
      end else begin
        lat = $urandom_range(0, 15);
        applyAlloc(port, lat, "rand alloc");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
